// File: rtl/mem_axi_pkg.sv
// Shared constants and FSM encoding for the uncached CPU data-port to AXI bridge.
package mem_axi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StRdAr   = 3'd1;
    localparam state_t StRdR    = 3'd2;
    localparam state_t StRdDone = 3'd3;
    localparam state_t StWrReq  = 3'd4;
    localparam state_t StWrB    = 3'd5;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

endpackage

// File: rtl/axi_aw_w_join.sv
// Raises AW and W valid together and retires each on its own handshake;
// both_done_o flags the cycle in which the last of the two completes.
module axi_aw_w_join (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic both_done_o
);

    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;

    always_comb begin
        awvalid_o   = active_i & ~aw_done_q;
        wvalid_o    = active_i & ~w_done_q;
        // Flags self-clear whenever the owner leaves the write-request phase.
        aw_done_d   = active_i & (aw_done_q | awready_i);
        w_done_d    = active_i & (w_done_q | wready_i);
        both_done_o = aw_done_d & w_done_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// Uncached data-memory bridge: one CPU load or store becomes one single-beat
// AXI transaction, with a single transaction outstanding at a time.
module mem_axi_bridge
    import mem_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 40
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_reset,
    input  logic [31:0]               Address,
    input  logic                      MemWrite,
    input  logic [31:0]               Write_data,
    input  logic [3:0]                Write_strb,
    input  logic                      MemRead,
    output logic                      Mem_Req_Ready,
    output logic [31:0]               Read_data,
    output logic                      Read_data_Valid,
    input  logic                      Read_data_Ready,
    output logic [AXI_ADDR_WIDTH-1:0] cpu_mem_araddr,
    output logic                      cpu_mem_arvalid,
    input  logic                      cpu_mem_arready,
    output logic [2:0]                cpu_mem_arsize,
    output logic [1:0]                cpu_mem_arburst,
    output logic [7:0]                cpu_mem_arlen,
    input  logic [31:0]               cpu_mem_rdata,
    input  logic                      cpu_mem_rvalid,
    output logic                      cpu_mem_rready,
    input  logic                      cpu_mem_rlast,
    output logic [AXI_ADDR_WIDTH-1:0] cpu_mem_awaddr,
    output logic                      cpu_mem_awvalid,
    input  logic                      cpu_mem_awready,
    output logic [2:0]                cpu_mem_awsize,
    output logic [1:0]                cpu_mem_awburst,
    output logic [7:0]                cpu_mem_awlen,
    output logic [31:0]               cpu_mem_wdata,
    output logic [3:0]                cpu_mem_wstrb,
    output logic                      cpu_mem_wvalid,
    input  logic                      cpu_mem_wready,
    output logic                      cpu_mem_wlast,
    input  logic                      cpu_mem_bvalid,
    output logic                      cpu_mem_bready
);

    localparam int unsigned PadW = AXI_ADDR_WIDTH - 32;

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        wr_active;
    logic        both_done;
    logic        unused_in;

    // Single-beat reads never need rlast; byte offset is dropped by word alignment.
    assign unused_in = ^{cpu_mem_rlast, Address[1:0]};

    assign accept    = (state_q == StIdle) & (MemWrite | MemRead);
    assign wr_active = (state_q == StWrReq);

    axi_aw_w_join u_aw_w_join (
        .clk_i       (cpu_clk),
        .rst_i       (cpu_reset),
        .active_i    (wr_active),
        .awready_i   (cpu_mem_awready),
        .wready_i    (cpu_mem_wready),
        .awvalid_o   (cpu_mem_awvalid),
        .wvalid_o    (cpu_mem_wvalid),
        .both_done_o (both_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                // A simultaneous read request is dropped in favour of the write.
                if (MemWrite) begin
                    state_d = StWrReq;
                end else if (MemRead) begin
                    state_d = StRdAr;
                end
            end
            StRdAr:   if (cpu_mem_arready) state_d = StRdR;
            StRdR:    if (cpu_mem_rvalid)  state_d = StRdDone;
            StRdDone: if (Read_data_Ready) state_d = StIdle;
            StWrReq:  if (both_done)       state_d = StWrB;
            StWrB:    if (cpu_mem_bvalid)  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= Address[31:2];
                wdata_q <= Write_data;
                wstrb_q <= Write_strb;
            end
            if ((state_q == StRdR) && cpu_mem_rvalid) begin
                rdata_q <= cpu_mem_rdata;
            end
        end
    end

    always_comb begin
        Mem_Req_Ready   = (state_q == StIdle) & ~cpu_reset;
        Read_data       = rdata_q;
        Read_data_Valid = (state_q == StRdDone);
        cpu_mem_araddr  = {{PadW{1'b0}}, addr_q, 2'b00};
        cpu_mem_awaddr  = {{PadW{1'b0}}, addr_q, 2'b00};
        cpu_mem_arvalid = (state_q == StRdAr);
        cpu_mem_rready  = (state_q == StRdR);
        cpu_mem_bready  = (state_q == StWrB);
        cpu_mem_arsize  = AXI_SIZE_4B;
        cpu_mem_awsize  = AXI_SIZE_4B;
        cpu_mem_arburst = AXI_BURST_INCR;
        cpu_mem_awburst = AXI_BURST_INCR;
        cpu_mem_arlen   = AXI_LEN_1BEAT;
        cpu_mem_awlen   = AXI_LEN_1BEAT;
        cpu_mem_wdata   = wdata_q;
        cpu_mem_wstrb   = wstrb_q;
        cpu_mem_wlast   = cpu_mem_wvalid;
    end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench for mem_axi_bridge: behavioural AXI slave with programmable
// stalls, protocol monitor, and a scoreboard of expected load data.
module tb_mem_axi_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_reset;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic [39:0] cpu_mem_araddr;
    logic        cpu_mem_arvalid;
    logic        cpu_mem_arready;
    logic [2:0]  cpu_mem_arsize;
    logic [1:0]  cpu_mem_arburst;
    logic [7:0]  cpu_mem_arlen;
    logic [31:0] cpu_mem_rdata;
    logic        cpu_mem_rvalid;
    logic        cpu_mem_rready;
    logic        cpu_mem_rlast;
    logic [39:0] cpu_mem_awaddr;
    logic        cpu_mem_awvalid;
    logic        cpu_mem_awready;
    logic [2:0]  cpu_mem_awsize;
    logic [1:0]  cpu_mem_awburst;
    logic [7:0]  cpu_mem_awlen;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_wvalid;
    logic        cpu_mem_wready;
    logic        cpu_mem_wlast;
    logic        cpu_mem_bvalid;
    logic        cpu_mem_bready;

    mem_axi_bridge #(.AXI_ADDR_WIDTH(40)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_reset       (cpu_reset),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .cpu_mem_araddr  (cpu_mem_araddr),
        .cpu_mem_arvalid (cpu_mem_arvalid),
        .cpu_mem_arready (cpu_mem_arready),
        .cpu_mem_arsize  (cpu_mem_arsize),
        .cpu_mem_arburst (cpu_mem_arburst),
        .cpu_mem_arlen   (cpu_mem_arlen),
        .cpu_mem_rdata   (cpu_mem_rdata),
        .cpu_mem_rvalid  (cpu_mem_rvalid),
        .cpu_mem_rready  (cpu_mem_rready),
        .cpu_mem_rlast   (cpu_mem_rlast),
        .cpu_mem_awaddr  (cpu_mem_awaddr),
        .cpu_mem_awvalid (cpu_mem_awvalid),
        .cpu_mem_awready (cpu_mem_awready),
        .cpu_mem_awsize  (cpu_mem_awsize),
        .cpu_mem_awburst (cpu_mem_awburst),
        .cpu_mem_awlen   (cpu_mem_awlen),
        .cpu_mem_wdata   (cpu_mem_wdata),
        .cpu_mem_wstrb   (cpu_mem_wstrb),
        .cpu_mem_wvalid  (cpu_mem_wvalid),
        .cpu_mem_wready  (cpu_mem_wready),
        .cpu_mem_wlast   (cpu_mem_wlast),
        .cpu_mem_bvalid  (cpu_mem_bvalid),
        .cpu_mem_bready  (cpu_mem_bready)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] slave_mem[16];

    // Slave configuration and state
    bit          rand_mode;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit          ar_seen, aw_seen, w_seen;
    bit          rd_pend, r_hs, aw_got, w_got, b_pend, b_hs;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    // Previous-cycle handshake state for the protocol monitor
    bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [39:0] p_araddr, p_awaddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    assign cpu_mem_rlast = cpu_mem_rvalid;

    function automatic int pick(input int d);
        return rand_mode ? int'($urandom_range(0, 3)) : d;
    endfunction

    task automatic apply_ref_store(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic slave_step();
        if (cpu_reset) begin
            cpu_mem_arready = 0; cpu_mem_rvalid = 0; cpu_mem_awready = 0;
            cpu_mem_wready = 0; cpu_mem_bvalid = 0;
            ar_seen = 0; aw_seen = 0; w_seen = 0; rd_pend = 0; r_hs = 0;
            aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0;
            p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
            return;
        end
        if (p_arv && !p_arr) begin
            checks++;
            if (cpu_mem_arvalid !== 1'b1 || cpu_mem_araddr !== p_araddr) begin
                errors++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h, required 1 and %h",
                         cpu_mem_arvalid, cpu_mem_araddr, p_araddr);
            end
        end
        if (p_awv && !p_awr) begin
            checks++;
            if (cpu_mem_awvalid !== 1'b1 || cpu_mem_awaddr !== p_awaddr) begin
                errors++;
                $display("FAIL aw_hold: awvalid=%b awaddr=%h, required 1 and %h",
                         cpu_mem_awvalid, cpu_mem_awaddr, p_awaddr);
            end
        end
        if (p_wv && !p_wr) begin
            checks++;
            if (cpu_mem_wvalid !== 1'b1 || cpu_mem_wdata !== p_wdata
                || cpu_mem_wstrb !== p_wstrb) begin
                errors++;
                $display("FAIL w_hold: wvalid=%b wdata=%h wstrb=%b, required 1 %h %b",
                         cpu_mem_wvalid, cpu_mem_wdata, cpu_mem_wstrb, p_wdata, p_wstrb);
            end
        end
        if (cpu_mem_arvalid) begin
            checks++;
            if (cpu_mem_arlen !== 8'd0 || cpu_mem_arsize !== 3'd2 || cpu_mem_arburst !== 2'b01
                || cpu_mem_araddr[1:0] !== 2'b00 || cpu_mem_araddr[39:32] !== 8'd0) begin
                errors++;
                $display("FAIL ar_fields: len=%0d size=%0d burst=%0d addr=%h, required 0 2 1 aligned",
                         cpu_mem_arlen, cpu_mem_arsize, cpu_mem_arburst, cpu_mem_araddr);
            end
        end
        if (cpu_mem_awvalid || cpu_mem_wvalid) begin
            checks++;
            if (cpu_mem_awlen !== 8'd0 || cpu_mem_awsize !== 3'd2 || cpu_mem_awburst !== 2'b01
                || cpu_mem_awaddr[1:0] !== 2'b00 || cpu_mem_awaddr[39:32] !== 8'd0
                || cpu_mem_wlast !== cpu_mem_wvalid) begin
                errors++;
                $display("FAIL aw_fields: len=%0d size=%0d burst=%0d addr=%h wlast=%b wvalid=%b",
                         cpu_mem_awlen, cpu_mem_awsize, cpu_mem_awburst, cpu_mem_awaddr,
                         cpu_mem_wlast, cpu_mem_wvalid);
            end
        end
        // R channel
        if (r_hs) begin cpu_mem_rvalid = 0; r_hs = 0; end
        if (rd_pend && !cpu_mem_rvalid) begin
            if (r_wait == 0) begin
                cpu_mem_rvalid = 1;
                cpu_mem_rdata  = slave_mem[rd_addr[5:2]];
            end else r_wait--;
        end
        if (cpu_mem_rvalid && cpu_mem_rready) begin r_hs = 1; rd_pend = 0; end
        // B channel
        if (b_hs) begin cpu_mem_bvalid = 0; b_hs = 0; end
        if (b_pend && !cpu_mem_bvalid) begin
            if (b_wait == 0) cpu_mem_bvalid = 1;
            else b_wait--;
        end
        if (cpu_mem_bvalid && cpu_mem_bready) begin b_hs = 1; b_pend = 0; end
        // AR channel
        cpu_mem_arready = 0;
        if (cpu_mem_arvalid) begin
            if (!ar_seen) begin ar_seen = 1; ar_wait = pick(ar_dly); end
            if (ar_wait == 0) begin
                cpu_mem_arready = 1; ar_seen = 0; rd_pend = 1;
                rd_addr = cpu_mem_araddr[31:0]; r_wait = pick(r_dly);
            end else ar_wait--;
        end
        // AW and W channels
        cpu_mem_awready = 0;
        if (cpu_mem_awvalid) begin
            if (!aw_seen) begin aw_seen = 1; aw_wait = pick(aw_dly); end
            if (aw_wait == 0) begin
                cpu_mem_awready = 1; aw_seen = 0; aw_got = 1; wr_addr = cpu_mem_awaddr[31:0];
            end else aw_wait--;
        end
        cpu_mem_wready = 0;
        if (cpu_mem_wvalid) begin
            if (!w_seen) begin w_seen = 1; w_wait = pick(w_dly); end
            if (w_wait == 0) begin
                cpu_mem_wready = 1; w_seen = 0; w_got = 1;
                wr_data = cpu_mem_wdata; wr_strb = cpu_mem_wstrb;
            end else w_wait--;
        end
        if (aw_got && w_got) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) slave_mem[wr_addr[5:2]][8*b +: 8] = wr_data[8*b +: 8];
            end
            aw_got = 0; w_got = 0; b_pend = 1; b_wait = pick(b_dly);
        end
        p_arv = cpu_mem_arvalid; p_arr = cpu_mem_arready; p_araddr = cpu_mem_araddr;
        p_awv = cpu_mem_awvalid; p_awr = cpu_mem_awready; p_awaddr = cpu_mem_awaddr;
        p_wv = cpu_mem_wvalid; p_wr = cpu_mem_wready;
        p_wdata = cpu_mem_wdata; p_wstrb = cpu_mem_wstrb;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
        slave_step();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && Mem_Req_Ready !== 1'b1; n++) tick();
        if (Mem_Req_Ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL idle_timeout: Mem_Req_Ready=%b, required 1", Mem_Req_Ready);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wait_idle();
        Address = a; Write_data = d; Write_strb = s; MemWrite = 1;
        apply_ref_store(a, d, s);
        tick();
        MemWrite = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input int rdy_dly);
        logic [31:0] exp;
        wait_idle();
        Address = a; MemRead = 1;
        exp_q.push_back(ref_mem[a[5:2]]);
        tick();
        MemRead = 0;
        for (int n = 0; n < 200 && Read_data_Valid !== 1'b1; n++) tick();
        exp = exp_q.pop_front();
        if (Read_data_Valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL load_timeout: Read_data_Valid=%b, required 1", Read_data_Valid);
            return;
        end
        for (int n = 0; n < rdy_dly; n++) begin
            checks++;
            if ({Read_data_Valid, Mem_Req_Ready} !== 2'b10 || Read_data !== exp) begin
                errors++;
                $display("FAIL load_hold: valid=%b req_ready=%b data=%h, required 1 0 %h",
                         Read_data_Valid, Mem_Req_Ready, Read_data, exp);
            end
            tick();
        end
        checks++;
        if (Read_data !== exp) begin
            errors++;
            $display("FAIL load_data: addr=%h got %h, required %h", a, Read_data, exp);
        end
        Read_data_Ready = 1;
        tick();
        Read_data_Ready = 0;
    endtask

    task automatic test_reset();
        cpu_reset = 1; Address = 0; MemWrite = 0; MemRead = 0; Write_data = 0;
        Write_strb = 0; Read_data_Ready = 0;
        cpu_mem_arready = 0; cpu_mem_rvalid = 0; cpu_mem_rdata = 0; cpu_mem_awready = 0;
        cpu_mem_wready = 0; cpu_mem_bvalid = 0;
        #3;
        checks++;
        if ({Mem_Req_Ready, Read_data_Valid, cpu_mem_arvalid, cpu_mem_rready, cpu_mem_awvalid,
             cpu_mem_wvalid, cpu_mem_bready} !== 7'd0 || Read_data !== 32'd0
            || cpu_mem_araddr !== 40'd0 || cpu_mem_awaddr !== 40'd0
            || cpu_mem_wdata !== 32'd0 || cpu_mem_wstrb !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b ar=%b r=%b aw=%b w=%b b=%b data=%h, required all 0",
                     Mem_Req_Ready, Read_data_Valid, cpu_mem_arvalid, cpu_mem_rready,
                     cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready, Read_data);
        end
        tick(); tick();
        cpu_reset = 0;
        tick();
        checks++;
        if (Mem_Req_Ready !== 1'b1 || cpu_mem_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: Mem_Req_Ready=%b arvalid=%b, required 1 0",
                     Mem_Req_Ready, cpu_mem_arvalid);
        end
    endtask

    task automatic test_load_basic();
        logic [31:0] exp;
        rand_mode = 0; ar_dly = 0; r_dly = 0;
        slave_mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
        wait_idle();
        Address = 32'h0000_1006; MemRead = 1;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        MemRead = 0;
        checks++;
        if (cpu_mem_arvalid !== 1'b1 || cpu_mem_araddr !== 40'h00_0000_1004
            || cpu_mem_arlen !== 8'd0 || cpu_mem_arsize !== 3'd2) begin
            errors++;
            $display("FAIL load_t1_ar: arvalid=%b araddr=%h len=%0d size=%0d, required 1 0000001004 0 2",
                     cpu_mem_arvalid, cpu_mem_araddr, cpu_mem_arlen, cpu_mem_arsize);
        end
        tick();
        checks++;
        if (cpu_mem_rready !== 1'b1 || cpu_mem_arvalid !== 1'b0 || Read_data_Valid !== 1'b0) begin
            errors++;
            $display("FAIL load_t2_r: rready=%b arvalid=%b valid=%b, required 1 0 0",
                     cpu_mem_rready, cpu_mem_arvalid, Read_data_Valid);
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (Read_data_Valid !== 1'b1 || Read_data !== exp) begin
            errors++;
            $display("FAIL load_t3_data: valid=%b data=%h, required 1 %h",
                     Read_data_Valid, Read_data, exp);
        end
        Read_data_Ready = 1;
        tick();
        Read_data_Ready = 0;
        checks++;
        if (Mem_Req_Ready !== 1'b1 || Read_data_Valid !== 1'b0) begin
            errors++;
            $display("FAIL load_return_idle: req_ready=%b valid=%b, required 1 0",
                     Mem_Req_Ready, Read_data_Valid);
        end
    endtask

    task automatic test_store_split();
        logic [4:0] got [6];
        logic [4:0] req [6];
        rand_mode = 0; aw_dly = 0; w_dly = 3; b_dly = 0;
        // {awvalid, wvalid, bready, Mem_Req_Ready, wlast} for cycles T+1..T+6
        req[0] = 5'b11001; req[1] = 5'b01001; req[2] = 5'b01001;
        req[3] = 5'b01001; req[4] = 5'b00100; req[5] = 5'b00010;
        do_store(32'h20, 32'h12345678, 4'b0110);
        checks++;
        if (cpu_mem_awaddr !== 40'h20 || cpu_mem_wdata !== 32'h12345678
            || cpu_mem_wstrb !== 4'b0110) begin
            errors++;
            $display("FAIL store_fields: awaddr=%h wdata=%h wstrb=%b, required 20 12345678 0110",
                     cpu_mem_awaddr, cpu_mem_wdata, cpu_mem_wstrb);
        end
        for (int c = 0; c < 6; c++) begin
            got[c] = {cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready, Mem_Req_Ready,
                      cpu_mem_wlast};
            checks++;
            if (got[c] !== req[c]) begin
                errors++;
                $display("FAIL store_split_T+%0d: aw/w/b/req/wlast=%b, required %b",
                         c + 1, got[c], req[c]);
            end
            if (c < 5) tick();
        end
        w_dly = 0;
        do_load(32'h20, 0);
    endtask

    task automatic test_backpressure();
        rand_mode = 0; ar_dly = 1; r_dly = 2;
        do_load(32'h14, 10);
    endtask

    task automatic test_both_req();
        bit saw_ar = 0;
        bit saw_aw = 0;
        rand_mode = 0; aw_dly = 1; w_dly = 0; b_dly = 1;
        wait_idle();
        Address = 32'h30; Write_data = 32'hCAFEF00D; Write_strb = 4'hF;
        MemRead = 1; MemWrite = 1;
        apply_ref_store(32'h30, 32'hCAFEF00D, 4'hF);
        tick();
        MemRead = 0; MemWrite = 0;
        for (int n = 0; n < 20 && Mem_Req_Ready !== 1'b1; n++) begin
            saw_ar |= cpu_mem_arvalid;
            saw_aw |= cpu_mem_awvalid;
            tick();
        end
        checks++;
        if (saw_ar !== 1'b0 || saw_aw !== 1'b1 || Mem_Req_Ready !== 1'b1) begin
            errors++;
            $display("FAIL both_req: saw_ar=%b saw_aw=%b req_ready=%b, required 0 1 1",
                     saw_ar, saw_aw, Mem_Req_Ready);
        end
        do_load(32'h30, 0);
    endtask

    task automatic test_reset_mid_read();
        rand_mode = 0; ar_dly = 0; r_dly = 6;
        wait_idle();
        Address = 32'h8; MemRead = 1;
        tick();
        MemRead = 0;
        tick();
        checks++;
        if (cpu_mem_rready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_rd_r: rready=%b, required 1", cpu_mem_rready);
        end
        #2;
        cpu_reset = 1;
        #1;
        checks++;
        if ({Mem_Req_Ready, Read_data_Valid, cpu_mem_arvalid, cpu_mem_rready, cpu_mem_awvalid,
             cpu_mem_wvalid, cpu_mem_bready} !== 7'd0 || Read_data !== 32'd0
            || cpu_mem_araddr !== 40'd0) begin
            errors++;
            $display("FAIL midrst_outputs: ready=%b valid=%b ar=%b r=%b aw=%b w=%b b=%b data=%h araddr=%h, required all 0",
                     Mem_Req_Ready, Read_data_Valid, cpu_mem_arvalid, cpu_mem_rready,
                     cpu_mem_awvalid, cpu_mem_wvalid, cpu_mem_bready, Read_data, cpu_mem_araddr);
        end
        tick(); tick();
        cpu_reset = 0;
        r_dly = 0;
        do_load(32'h8, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        rand_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 1) do_store(a, $urandom(), 4'($urandom_range(0, 15)));
            else do_load(a, int'($urandom_range(0, 2)));
        end
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = (i * 32'h0101_0101) ^ 32'hC0FF_EE00;
            ref_mem[i]   = (i * 32'h0101_0101) ^ 32'hC0FF_EE00;
        end
        rand_mode = 0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        test_reset();
        test_load_basic();
        test_store_split();
        test_backpressure();
        test_both_req();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Uncached data-memory bridge between the custom CPU's data port (Address/MemWrite/MemRead/Read_data handshake) and the data-side AXI master port feeding `cpu_to_mem_axi_2x1_arb`. It turns each CPU load into one single-beat AXI read and each CPU store into one single-beat AXI write. It handles one outstanding transaction at a time and presents read data back to the CPU with a valid/ready handshake. It is the plain alternative to the data cache, selected when `USE_DCACHE` is undefined.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 40, width of the AXI address buses; upper bits above 32 are driven 0.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- cpu_clk  in  1  core clock.
- cpu_reset  in  1  asynchronous, active-high reset.
- Address  in  32  byte address of the load or store.
- MemWrite  in  1  store request.
- Write_data  in  32  store data.
- Write_strb  in  4  store byte enables.
- MemRead  in  1  load request.
- Mem_Req_Ready  out  1  request accepted when high with MemRead or MemWrite.
- Read_data  out  32  load data.
- Read_data_Valid  out  1  Read_data is valid.
- Read_data_Ready  in  1  CPU consumes Read_data.
- cpu_mem_araddr / arvalid / arready / arsize / arburst / arlen  out/out/in/out/out/out  AXI_ADDR_WIDTH/1/1/3/2/8  AXI read address channel.
- cpu_mem_rdata / rvalid / rready / rlast  in/in/out/in  32/1/1/1  AXI read data channel.
- cpu_mem_awaddr / awvalid / awready / awsize / awburst / awlen  out/out/in/out/out/out  AXI_ADDR_WIDTH/1/1/3/2/8  AXI write address channel.
- cpu_mem_wdata / wstrb / wvalid / wready / wlast  out/out/out/in/out  32/4/1/1/1  AXI write data channel.
- cpu_mem_bvalid / bready  in/out  1/1  AXI write response channel.

## Operation
- FSM states: IDLE, RD_AR, RD_R, RD_DONE, WR_REQ, WR_B.
- Mem_Req_Ready is 1 only in IDLE.
- Request acceptance: at a clock edge in IDLE with MemWrite or MemRead high, register Address, Write_data and Write_strb.
  - MemWrite goes to WR_REQ.
  - MemRead goes to RD_AR.
  - If both are high, the write wins and the read is dropped.
- Address handling: araddr and awaddr are {zeros, Address[31:2], 2'b00}.
- Fixed AXI fields: arsize = awsize = 3'b010, arburst = awburst = 2'b01 (INCR), arlen = awlen = 0, wlast = 1 whenever wvalid is high.
- RD_AR: arvalid = 1. On arready, go to RD_R.
- RD_R: rready = 1. On rvalid, capture rdata into Read_data and go to RD_DONE. rlast is not checked, because every read is a single beat.
- RD_DONE: Read_data_Valid = 1, with Read_data held stable. On Read_data_Ready, go to IDLE.
- WR_REQ: awvalid and wvalid are both raised on entry.
  - Each drops independently after its own handshake; aw_done and w_done flags track this.
  - When both handshakes have completed, go to WR_B. This covers the same-cycle case and either order.
- WR_B: bready = 1. On bvalid, go to IDLE. A store produces no CPU-side response.
- rresp and bresp are ignored.

## Timing
- Reset values: FSM in IDLE. Every valid/ready output is 0, Read_data is 0, and address/data outputs are 0.
  - Mem_Req_Ready becomes 1 on the first cycle after reset deasserts.
- Reset mid-transaction: asynchronously abandon the transaction and return to IDLE; the AXI slave shares the reset.
- Minimum load latency (T = accept edge, zero-wait slave):
  - arvalid high in cycle T+1.
  - rready high in cycle T+2.
  - Read_data_Valid high in cycle T+3.
  - Next Mem_Req_Ready one cycle after Read_data_Ready is sampled.
- Minimum store latency: awvalid/wvalid high in cycle T+1, bready high in T+2, back in IDLE in T+3.
- AXI valid signals never drop before their handshake. araddr, awaddr, wdata and wstrb stay constant while their valid is high.
- Read_data_Valid stays high until Read_data_Ready; back-pressure of any length is legal.

## Structure
- Shared package mem_axi_pkg holds:
  - The state enum.
  - AXI_BURST_INCR = 2'b01.
  - AXI_SIZE_4B = 3'b010.
  - AXI_LEN_1BEAT = 8'd0.
- One natural sub-module, axi_aw_w_join. It tracks the aw_done/w_done flags and generates awvalid, wvalid and both_done. It is reusable by the dcache write-back path.

## Test plan
- Load, zero-wait slave: Address 0x0000_1006 → araddr 0x00_0000_1004, arlen 0, arsize 2. rdata 0xDEADBEEF → Read_data 0xDEADBEEF with Read_data_Valid at T+3.
- Store with aw and w handshakes separated:
  - Stimulus: Address 0x20, Write_data 0x12345678, strb 4'b0110; awready at T+1, wready at T+4.
  - Required: awvalid drops at T+2 while wvalid stays high until T+4; bready starts at T+5; Mem_Req_Ready returns after bvalid.
- Read_data_Ready withheld for 10 cycles: Read_data_Valid and Read_data are held unchanged, and Mem_Req_Ready stays 0 throughout.
- MemRead and MemWrite both high: only an AW/W transaction is issued, and arvalid stays 0.
- Reset asserted while in RD_R: all outputs go to 0 immediately. After release, a fresh load completes correctly.
- Randomised arready/rvalid/awready/wready/bvalid stalls over 1000 mixed loads and stores: read data matches a scoreboard memory model, and no AXI protocol violation occurs.
